// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, MSB-first payload, optional even parity.
// One bit per clock; the line idles at IDLE_BIT between frames.
module sync_frame_tx #(
    parameter int                DATA_W    = 8,
    parameter int                SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC      = 4'b0110,
    parameter bit                PARITY_EN = 1'b1,
    parameter logic              IDLE_BIT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              tx,
    output logic              tx_en,
    output logic              done
);

    localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PAR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              tx_d, tx_en_d, ready_d, done_d;
    logic [SYNC_W-1:0] sync_shift;

    // NOTE: every register below uses <= so all updates take effect together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx      <= IDLE_BIT;
            tx_en   <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx      <= tx_d;
            tx_en   <= tx_en_d;
            ready   <= ready_d;
            done    <= done_d;
        end
    end

    // The state leads tx by one cycle: each state decides the bit registered at the next edge.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tx_d       = IDLE_BIT;
        tx_en_d    = 1'b0;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        sync_shift = SYNC << cnt_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                // ready is still low in the last-bit cycle, which enforces the idle gap.
                if (start && ready) begin
                    shreg_d = data_in;
                    par_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                    ready_d = 1'b0;
                end
            end

            ST_SYNC: begin
                tx_d    = sync_shift[SYNC_W-1];
                tx_en_d = 1'b1;
                if (cnt_q == SYNC_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                tx_d    = shreg_q[DATA_W-1];
                tx_en_d = 1'b1;
                shreg_d = shreg_q << 1;
                // Parity accumulates over the latched payload as it shifts out.
                par_d   = par_q ^ shreg_q[DATA_W-1];
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    if (PARITY_EN) begin
                        state_d = ST_PAR;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_PAR: begin
                tx_d    = par_q;
                tx_en_d = 1'b1;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed + randomized bench for sync_frame_tx: parity and no-parity builds,
// busy rejection, mid-frame reset and a 0110-detector loopback.
module tb_sync_frame_tx;

    localparam int DATA_W = 8;
    localparam int SYNC_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_r [2];
    logic [7:0] din     [2];
    logic       ready_o [2];
    logic       tx_o    [2];
    logic       tx_en_o [2];
    logic       done_o  [2];

    int errors = 0;
    int checks = 0;

    logic [3:0] sync_word = 4'b0110;

    always #5 clk = ~clk;

    sync_frame_tx u_par (
        .clk(clk), .rst(rst), .start(start_r[0]), .data_in(din[0]),
        .ready(ready_o[0]), .tx(tx_o[0]), .tx_en(tx_en_o[0]), .done(done_o[0])
    );

    sync_frame_tx #(.PARITY_EN(1'b0)) u_nopar (
        .clk(clk), .rst(rst), .start(start_r[1]), .data_in(din[1]),
        .ready(ready_o[1]), .tx(tx_o[1]), .tx_en(tx_en_o[1]), .done(done_o[1])
    );

    // Stand-in for the 0110 sequence detector listening on the parity build's line.
    logic [3:0] det_hist;
    logic       det_y;
    always_ff @(posedge clk) begin
        if (rst) begin
            det_hist <= 4'hF;
            det_y    <= 1'b0;
        end else begin
            det_hist <= {det_hist[2:0], tx_o[0]};
            det_y    <= ({det_hist[2:0], tx_o[0]} == 4'b0110);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input int sel, input string tag);
        chk({tag, "_tx"},    tx_o[sel],    1);
        chk({tag, "_tx_en"}, tx_en_o[sel], 0);
        chk({tag, "_ready"}, ready_o[sel], 1);
        chk({tag, "_done"},  done_o[sel],  0);
    endtask

    // Sends one frame on DUT sel and checks every cycle against the expected bit list.
    task automatic run_frame(input int sel, input logic [7:0] d, input bit poke_busy,
                             input int rst_at, input bit chk_idle_y);
        bit q[$];
        int len;
        q = {};
        for (int i = SYNC_W - 1; i >= 0; i--) q.push_back(sync_word[i]);
        for (int i = DATA_W - 1; i >= 0; i--) q.push_back(d[i]);
        if (sel == 0) q.push_back(($countones(d) % 2) == 1);
        len = q.size();

        chk("ready_before_start", ready_o[sel], 1);
        start_r[sel] = 1'b1;
        din[sel]     = d;
        tick();
        start_r[sel] = 1'b0;
        din[sel]     = 8'($urandom);
        chk("accept_ready", ready_o[sel], 0);
        chk("accept_tx_en", tx_en_o[sel], 0);
        chk("accept_tx",    tx_o[sel],    1);
        if (chk_idle_y) chk("idle_y_accept", det_y, 0);

        for (int i = 0; i < len; i++) begin
            tick();
            din[sel] = 8'($urandom);
            chk($sformatf("bit%0d_tx", i), tx_o[sel], q[i]);
            chk($sformatf("bit%0d_tx_en", i), tx_en_o[sel], 1);
            chk($sformatf("bit%0d_done", i), done_o[sel], (i == len - 1));
            chk($sformatf("bit%0d_ready", i), ready_o[sel], 0);
            if (sel == 0 && i == SYNC_W) chk("det_y_after_sync", det_y, 1);
            start_r[sel] = poke_busy && (i == 2 || i == len - 1);
            if (start_r[sel]) din[sel] = 8'hFF;
            if (rst_at == i + 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                start_r[sel] = 1'b0;
                chk_reset_vals(sel, "midframe_rst");
                return;
            end
        end

        tick();
        start_r[sel] = 1'b0;
        chk("end_ready", ready_o[sel], 1);
        chk("end_tx",    tx_o[sel],    1);
        chk("end_tx_en", tx_en_o[sel], 0);
        chk("end_done",  done_o[sel],  0);
        if (chk_idle_y) chk("idle_y_end", det_y, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start_r[0] = 1'b1;
        start_r[1] = 1'b1;
        din[0]     = 8'($urandom);
        din[1]     = 8'($urandom);

        // Reset held with start asserted: no frame may begin.
        tick();
        chk_reset_vals(0, "rst1");
        tick();
        chk_reset_vals(0, "rst2");
        chk_reset_vals(1, "rst2_nopar");
        rst        = 1'b0;
        start_r[0] = 1'b0;
        start_r[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_tx_en", tx_en_o[0], 0);
            chk("post_rst_ready", ready_o[0], 1);
        end

        // Reference frames.
        run_frame(0, 8'hA5, 1'b0, 0, 1'b0);
        tick();
        run_frame(0, 8'h07, 1'b0, 0, 1'b0);
        tick();
        run_frame(1, 8'h07, 1'b0, 0, 1'b0);
        tick();

        // Busy rejection: pokes at frame cycles 3 and 13 must not launch a second frame.
        run_frame(0, 8'h3C, 1'b1, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("busy_no_second_frame", tx_en_o[0], 0);
            chk("busy_ready", ready_o[0], 1);
        end

        // Reset on the 6th frame bit, then a clean frame.
        run_frame(0, 8'h5A, 1'b0, 6, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("after_abort_done", done_o[0], 0);
            chk("after_abort_tx_en", tx_en_o[0], 0);
        end
        run_frame(0, 8'hC3, 1'b0, 0, 1'b0);
        tick();

        // Randomized payloads on both builds.
        for (int k = 0; k < 6; k++) begin
            run_frame(0, 8'($urandom), 1'b0, 0, 1'b0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            run_frame(1, 8'($urandom), 1'b0, 0, 1'b0);
            tick();
        end

        // Loopback: back-to-back frames, start as soon as ready returns.
        run_frame(0, 8'h00, 1'b0, 0, 1'b1);
        run_frame(0, 8'hA5, 1'b0, 0, 1'b1);
        tick();
        chk("loop_idle_y", det_y, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
